map_access_arbiter: RTL and testbench

- Shares the single combinational map lookup port (col/row in, 1-bit wall flag out) between two requesters.
- Requester A is the ray tracer's DDA stepper and has high priority.
- Requester B is the low-priority map-overlay/debug reader.
- One lookup per clock. Each result is registered and returned with a one-cycle ack pulse. A starvation counter guarantees B eventually wins.

---
 rtl/map_access_arbiter.sv | 83 ++++++++
 tb/tb_map_access_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_access_arbiter.sv
// Two-port arbiter for the single combinational map lookup port.
// A (DDA stepper) has priority; B (overlay reader) wins after STARVE_LIMIT denied cycles.
module map_access_arbiter #(
  parameter int unsigned MAP_WBITS    = 4,
  parameter int unsigned MAP_HBITS    = 4,
  parameter int unsigned STARVE_LIMIT = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_a_req,
  input  logic [MAP_WBITS-1:0] i_a_col,
  input  logic [MAP_HBITS-1:0] i_a_row,
  output logic                 o_a_ack,
  output logic                 o_a_val,
  input  logic                 i_b_req,
  input  logic [MAP_WBITS-1:0] i_b_col,
  input  logic [MAP_HBITS-1:0] i_b_row,
  output logic                 o_b_ack,
  output logic                 o_b_val,
  output logic [MAP_WBITS-1:0] o_map_col,
  output logic [MAP_HBITS-1:0] o_map_row,
  input  logic                 i_map_val,
  output logic                 o_starve
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            a_ack_q, a_val_q, b_ack_q, b_val_q;
  logic            elig_a, elig_b, starve, grant_a, grant_b;

  // A requester sitting in its own ack cycle is not eligible, which forces A/B alternation.
  assign elig_a  = i_a_req & ~a_ack_q;
  assign elig_b  = i_b_req & ~b_ack_q;
  assign starve  = elig_b & (cnt_q == CntMax);
  assign grant_a = elig_a & ~starve;
  assign grant_b = starve | (elig_b & ~elig_a);

  always_comb begin
    o_map_col = '0;
    o_map_row = '0;
    if (grant_a) begin
      o_map_col = i_a_col;
      o_map_row = i_a_row;
    end else if (grant_b) begin
      o_map_col = i_b_col;
      o_map_row = i_b_row;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (grant_b || !elig_b) begin
      cnt_d = '0;
    end else if (grant_a && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      a_ack_q <= 1'b0;
      a_val_q <= 1'b0;
      b_ack_q <= 1'b0;
      b_val_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_ack_q <= grant_a;
      b_ack_q <= grant_b;
      if (grant_a) a_val_q <= i_map_val;
      if (grant_b) b_val_q <= i_map_val;
    end
  end

  assign o_a_ack  = a_ack_q;
  assign o_a_val  = a_val_q;
  assign o_b_ack  = b_ack_q;
  assign o_b_val  = b_val_q;
  assign o_starve = starve;

endmodule

// File: tb/tb_map_access_arbiter.sv
// Scoreboard bench for map_access_arbiter: a behavioural model queues expected acks,
// an independent monitor pops them whenever the DUT pulses an ack.
module tb_map_access_arbiter;

  localparam int unsigned W   = 4;
  localparam int unsigned H   = 4;
  localparam int unsigned LIM = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         a_req, b_req;
  logic [W-1:0] a_col, b_col;
  logic [H-1:0] a_row, b_row;
  logic         a_ack, a_val, b_ack, b_val;
  logic [W-1:0] map_col;
  logic [H-1:0] map_row;
  logic         map_val;
  logic         starve;

  map_access_arbiter #(
    .MAP_WBITS   (W),
    .MAP_HBITS   (H),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_a_req  (a_req),
    .i_a_col  (a_col),
    .i_a_row  (a_row),
    .o_a_ack  (a_ack),
    .o_a_val  (a_val),
    .i_b_req  (b_req),
    .i_b_col  (b_col),
    .i_b_row  (b_row),
    .o_b_ack  (b_ack),
    .o_b_val  (b_val),
    .o_map_col(map_col),
    .o_map_row(map_row),
    .i_map_val(map_val),
    .o_starve (starve)
  );

  always #5 clk = ~clk;

  // Map ROM: border cells are walls, interior has a sparse pattern.
  function automatic logic rom(input logic [W-1:0] c, input logic [H-1:0] r);
    int ci, ri;
    ci = int'(c);
    ri = int'(r);
    if (ci == 0 || ci == 15 || ri == 0 || ri == 15) return 1'b1;
    return ((ci * 3 + ri) % 7) == 0;
  endfunction

  assign map_val = rom(map_col, map_row);

  typedef struct {
    int   due;
    logic val;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   force_a = 1'b0;
  bit   done = 1'b0;
  bit   drained = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks who was served last cycle and how long B has waited.
  bit m_a_ack, m_b_ack;
  int m_wait;

  always @(negedge clk) begin
    bit           ea, eb, st, ga, gb;
    logic [W-1:0] ecol;
    logic [H-1:0] erow;
    if (!reset_n) begin
      m_a_ack = 1'b0;
      m_b_ack = 1'b0;
      m_wait  = 0;
      chk("rst_a_val", int'(a_val), 0);
      chk("rst_b_val", int'(b_val), 0);
      chk("rst_starve", int'(starve), 0);
    end else begin
      ea = force_a || (a_req && !m_a_ack);
      eb = b_req && !m_b_ack;
      st = eb && (m_wait == int'(LIM));
      ga = ea && !st;
      gb = eb && !ga;
      ecol = '0;
      erow = '0;
      if (ga) begin
        ecol = a_col;
        erow = a_row;
        a_q.push_back('{due: cyc + 1, val: rom(a_col, a_row)});
      end else if (gb) begin
        ecol = b_col;
        erow = b_row;
        b_q.push_back('{due: cyc + 1, val: rom(b_col, b_row)});
      end
      chk("map_col", int'(map_col), int'(ecol));
      chk("map_row", int'(map_row), int'(erow));
      chk("starve", int'(starve), int'(st));
      m_a_ack = ga;
      m_b_ack = gb;
      if (gb || !eb) m_wait = 0;
      else if (m_wait < int'(LIM)) m_wait = m_wait + 1;
    end
  end

  // Monitor: consumes expectations only when the DUT presents an ack.
  int a_rd = 0;
  int b_rd = 0;
  int starve_seen = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      a_rd = a_q.size();
      b_rd = b_q.size();
      chk("rst_a_ack", int'(a_ack), 0);
      chk("rst_b_ack", int'(b_ack), 0);
    end else begin
      if (starve) starve_seen++;
      if (a_ack) begin
        if (a_rd < a_q.size() && a_q[a_rd].due == cyc) begin
          chk("a_val", int'(a_val), int'(a_q[a_rd].val));
          a_rd++;
        end else begin
          chk("a_ack_unexpected", 1, 0);
        end
      end else if (a_rd < a_q.size() && a_q[a_rd].due <= cyc) begin
        chk("a_ack_missing", 0, 1);
        a_rd++;
      end
      if (b_ack) begin
        if (b_rd < b_q.size() && b_q[b_rd].due == cyc) begin
          chk("b_val", int'(b_val), int'(b_q[b_rd].val));
          b_rd++;
        end else begin
          chk("b_ack_unexpected", 1, 0);
        end
      end else if (b_rd < b_q.size() && b_q[b_rd].due <= cyc) begin
        chk("b_ack_missing", 0, 1);
        b_rd++;
      end
    end
    if (done && !drained) begin
      chk("a_drained", a_q.size() - a_rd, 0);
      chk("b_drained", b_q.size() - b_rd, 0);
      chk("starve_seen", int'(starve_seen > 0), 1);
      drained = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    a_req = 1'b0; a_col = '0; a_row = '0;
    b_req = 1'b0; b_col = '0; b_row = '0;
    step(3);
    reset_n = 1'b1;
    step(1);

    // Single A to a border cell.
    a_req = 1'b1; a_col = 4'd0; a_row = 4'd5;
    step(1);
    a_req = 1'b0;
    step(2);

    // Single B to an interior cell.
    b_req = 1'b1; b_col = 4'd9; b_row = 4'd9;
    step(1);
    b_req = 1'b0;
    step(2);

    // Simultaneous first request, held: A,B,A,B alternation.
    a_req = 1'b1; a_col = 4'd15; a_row = 4'd3;
    b_req = 1'b1; b_col = 4'd9;  b_row = 4'd9;
    step(6);
    a_req = 1'b0; b_req = 1'b0;
    step(2);

    // Back-to-back A alone, new address on each ack cycle.
    for (int i = 0; i < 5; i++) begin
      a_req = 1'b1;
      a_col = W'(i * 5 + 1);
      a_row = H'(i * 3 + 2);
      step(2);
    end
    a_req = 1'b0;
    step(2);

    // Starvation: A forced eligible every cycle, B held.
    force_a = 1'b1;
    force dut.elig_a = 1'b1;
    a_req = 1'b1; a_col = 4'd3; a_row = 4'd0;
    b_req = 1'b1; b_col = 4'd7; b_row = 4'd7;
    step(7);
    release dut.elig_a;
    force_a = 1'b0;
    a_req = 1'b0; b_req = 1'b0;
    step(2);

    // Reset in A's grant cycle: that grant is discarded, then re-granted after release.
    a_req = 1'b1; a_col = 4'd15; a_row = 4'd8;
    @(negedge clk);
    #2 reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(3);
    a_req = 1'b0;
    step(2);

    // Randomized traffic, holding each request until acked with occasional drops.
    for (int i = 0; i < 400; i++) begin
      if (a_ack || !a_req) begin
        a_req = ($urandom_range(0, 3) != 0);
        a_col = W'($urandom);
        a_row = H'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        a_req = 1'b0;
      end
      if (b_ack || !b_req) begin
        b_req = ($urandom_range(0, 2) != 0);
        b_col = W'($urandom);
        b_row = H'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        b_req = 1'b0;
      end
      step(1);
    end
    a_req = 1'b0; b_req = 1'b0;
    step(3);

    done = 1'b1;
    step(2);
    if (!drained) begin
      total++;
      bad++;
      $display("FAIL final_check: got 0 expected 1");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
